strobe_meter: RTL

Measures the interval between rising edges of a periodic strobe input, in clock cycles. It reports each measured period, flags when the strobe is stable ("locked"), and flags when the strobe has stopped ("lost"). It is the receiving end of a `strobe_gen` link: it checks tick rates, debounce clocks and heartbeat pulses against their expected frequency. It feeds display and status logic on the same clock domain.

---
 rtl/strobe_meter_pkg.sv | 18 +
 rtl/strobe_edge_detect.sv | 39 +++
 rtl/strobe_meter.sv | 101 ++++++++++
 3 files changed

// File: rtl/strobe_meter_pkg.sv
// Shared types and helpers for the strobe period meter.
package strobe_meter_pkg;

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    COUNT      = 1'b1
  } strobe_meter_state_t;

  // Larger minus smaller, so the result never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for the strobe input.
// STROBE_METER_SYNC_EN adds a two-flop synchronizer ahead of the edge register.
module strobe_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic strobe_in,
  output logic strobe_edge
);

  logic strobe_s;
  logic strobe_prev;

`ifdef STROBE_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], strobe_in};
    end
  end

  assign strobe_s = sync_q[1];
`else
  assign strobe_s = strobe_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      strobe_prev <= 1'b0;
    end else begin
      strobe_prev <= strobe_s;
    end
  end

  assign strobe_edge = strobe_s & ~strobe_prev;

endmodule

// File: rtl/strobe_meter.sv
// Measures strobe period in clk cycles, reports lock and loss of strobe.
// Optional input synchronizer: STROBE_METER_SYNC_EN (see strobe_edge_detect).
module strobe_meter
  import strobe_meter_pkg::*;
#(
  parameter int unsigned clk_mhz    = 50,
  parameter int unsigned min_hz     = 1,
  parameter int unsigned tol_cycles = 2,
  localparam int unsigned timeout_cycles = clk_mhz * 1000 * 1000 / min_hz,
  localparam int          w_cnt          = $clog2(timeout_cycles + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe_in,
  output logic [w_cnt-1:0]    period,
  output logic                period_valid,
  output logic                locked,
  output logic                lost,
  output strobe_meter_state_t dbg_state
);

  localparam logic [w_cnt-1:0] timeout_w = w_cnt'(timeout_cycles);

  // Handshake: period_valid is a pure one-cycle strobe with no ready;
  // consumers must capture period in the cycle period_valid is high.

  strobe_meter_state_t state;
  strobe_meter_state_t state_next;

  logic             strobe_edge;
  logic [w_cnt-1:0] cnt;
  logic [w_cnt-1:0] prev_period;
  logic             have_prev;
  logic             stable;

  strobe_edge_detect u_edge (
    .clk         (clk),
    .rst         (rst),
    .strobe_in   (strobe_in),
    .strobe_edge (strobe_edge)
  );

  assign stable    = abs_diff(32'(cnt), 32'(prev_period)) <= tol_cycles;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WAIT_FIRST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_FIRST: if (strobe_edge) state_next = COUNT;
      // An edge coinciding with the timeout is still a valid measurement.
      COUNT:      if (!strobe_edge && (cnt == timeout_w)) state_next = WAIT_FIRST;
      default:    state_next = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
      prev_period  <= '0;
      have_prev    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      lost         <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (strobe_edge) cnt <= w_cnt'(1);
        end
        COUNT: begin
          if (strobe_edge) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= w_cnt'(1);
            prev_period  <= cnt;
            have_prev    <= 1'b1;
            if (have_prev) locked <= stable;
          end else if (cnt == timeout_w) begin
            lost      <= 1'b1;
            locked    <= 1'b0;
            have_prev <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
